btn_debouncer: RTL and testbench

Debounces the raw active-high push-button for the 0-999 display counter and emits clean single-cycle event pulses in the `sysclk` domain. The counter consumes `press_pulse` as its increment enable instead of doing its own edge detection on a bare two-flop synchronizer. The block has three parts: a two-flop input synchronizer, a stability-timer FSM, and an optional auto-repeat generator.

---
 rtl/btn_debouncer_pkg.sv | 17 +
 rtl/sync_2ff.sv | 22 ++
 rtl/btn_debouncer.sv | 120 ++++++++++++
 tb/tb_btn_debouncer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/btn_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Default timing assumes the 12 MHz board clock.
package btn_debouncer_pkg;

    localparam int SYSCLK_HZ                = 12000000;
    localparam int DB_CYCLES_DEFAULT        = 120000;   // 10 ms
    localparam int DB_REPEAT_DELAY_DEFAULT  = 6000000;  // 500 ms
    localparam int DB_REPEAT_PERIOD_DEFAULT = 1200000;  // 100 ms

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with async active-high reset.
// Reusable for any asynchronous board input entering the sysclk domain.
module sync_2ff (
    input  logic sysclk,
    input  logic rst_sync2,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sysclk or posedge rst_sync2) begin
        if (rst_sync2) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer: sync, stability-timer FSM, registered level and pulses.
// Define BTN_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = DB_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = DB_REPEAT_PERIOD_DEFAULT
) (
    input  logic sysclk,
    input  logic rst_sync2,
    input  logic btn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("btn_debouncer: DEBOUNCE_CYCLES must be >= 2");
        end
        if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
            $error("btn_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       btn_s;
    db_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic       accept;
    logic       rep_fire;

    sync_2ff u_sync (
        .sysclk    (sysclk),
        .rst_sync2 (rst_sync2),
        .d         (btn),
        .q         (btn_s)
    );

    assign accept = (state == PRESS_WAIT) && btn_s && (cnt == CNT_LAST);

`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);

    logic [REP_W-1:0] rep_cnt;
    logic             holding;

    assign holding  = (state == PRESSED) && btn_s;
    assign rep_fire = holding && (rep_cnt == '0);

    // Down-counter; preloaded with DELAY-1 whenever the button is not
    // steadily held, so the first repeat lands REPEAT_DELAY after accept.
    always_ff @(posedge sysclk or posedge rst_sync2) begin
        if (rst_sync2)
            rep_cnt <= '0;
        else if (!holding)
            rep_cnt <= REP_W'(REPEAT_DELAY - 1);
        else if (rep_cnt == '0)
            rep_cnt <= REP_W'(REPEAT_PERIOD - 1);
        else
            rep_cnt <= rep_cnt - 1'b1;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge rst_sync2) begin
        if (rst_sync2) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= accept | rep_fire;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed self-checking bench for btn_debouncer (DEBOUNCE_CYCLES=4).
// Auto-repeat expectations follow BTN_DEBOUNCER_AUTOREPEAT_EN.
module tb_btn_debouncer;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int ACC = DC + 2;  // edge index of accept/release after first capture

    logic sysclk    = 1'b0;
    logic rst_sync2 = 1'b1;
    logic btn       = 1'b0;
    logic btn_level, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .sysclk        (sysclk),
        .rst_sync2     (rst_sync2),
        .btn           (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    task automatic step;
        @(posedge sysclk);
        #1;
    endtask

    // Expected press_pulse after edge k of a continuous hold starting at edge 0.
    function automatic logic exp_press(int k);
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
        return (k == ACC) || (k >= ACC + RD && ((k - ACC - RD) % RP) == 0);
`else
        return (k == ACC);
`endif
    endfunction

    task automatic settle;
        btn = 1'b0;
        repeat (12) step;
    endtask

    task automatic test_reset;
        rst_sync2 = 1'b1;
        step; step;
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL reset btn_level got=%b exp=0", btn_level); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset press_pulse got=%b exp=0", press_pulse); end
        checks++; if (release_pulse !== 1'b0) begin errors++; $display("FAIL reset release_pulse got=%b exp=0", release_pulse); end
        rst_sync2 = 1'b0;
        step;
        checks++; if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin errors++; $display("FAIL reset_release outs got=%b exp=000", {btn_level, press_pulse, release_pulse}); end
    endtask

    task automatic test_clean_press;
        btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step;
            checks++; if (press_pulse !== exp_press(k)) begin errors++; $display("FAIL clean_press k=%0d press_pulse got=%b exp=%b", k, press_pulse, exp_press(k)); end
            checks++; if (btn_level !== (k >= ACC)) begin errors++; $display("FAIL clean_press k=%0d btn_level got=%b exp=%b", k, btn_level, k >= ACC); end
            checks++; if (release_pulse !== 1'b0) begin errors++; $display("FAIL clean_press k=%0d release_pulse got=%b exp=0", k, release_pulse); end
        end
        btn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step;
            checks++; if (release_pulse !== (k == ACC)) begin errors++; $display("FAIL clean_release k=%0d release_pulse got=%b exp=%b", k, release_pulse, k == ACC); end
            checks++; if (btn_level !== (k < ACC)) begin errors++; $display("FAIL clean_release k=%0d btn_level got=%b exp=%b", k, btn_level, k < ACC); end
            checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL clean_release k=%0d press_pulse got=%b exp=0", k, press_pulse); end
        end
        settle;
    endtask

    task automatic test_glitch;
        for (int k = 0; k < 12; k++) begin
            btn = (k < 3);
            step;
            checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL glitch k=%0d press_pulse got=%b exp=0", k, press_pulse); end
            checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL glitch k=%0d btn_level got=%b exp=0", k, btn_level); end
        end
        settle;
    endtask

    task automatic test_bouncy_release;
        int nrel;
        nrel = 0;
        btn = 1'b1;
        repeat (8) step;
        checks++; if (btn_level !== 1'b1) begin errors++; $display("FAIL bounce_setup btn_level got=%b exp=1", btn_level); end
        // captured sequence 0,1,0,0,... ; stable 0 begins at capture edge 2
        for (int k = 0; k < 14; k++) begin
            btn = (k == 1);
            step;
            if (release_pulse === 1'b1) nrel++;
            checks++; if (release_pulse !== (k == 8)) begin errors++; $display("FAIL bounce k=%0d release_pulse got=%b exp=%b", k, release_pulse, k == 8); end
            checks++; if (btn_level !== (k < 8)) begin errors++; $display("FAIL bounce k=%0d btn_level got=%b exp=%b", k, btn_level, k < 8); end
            checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL bounce k=%0d press_pulse got=%b exp=0", k, press_pulse); end
        end
        checks++; if (nrel !== 1) begin errors++; $display("FAIL bounce_count releases got=%0d exp=1", nrel); end
        settle;
    endtask

    task automatic test_reset_mid_press;
        btn = 1'b1;
        repeat (4) step;
        rst_sync2 = 1'b1;
        #1;
        checks++; if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin errors++; $display("FAIL rst_wait outs got=%b exp=000", {btn_level, press_pulse, release_pulse}); end
        step; step;
        rst_sync2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step;
            checks++; if (press_pulse !== (k == ACC)) begin errors++; $display("FAIL rst_requal k=%0d press_pulse got=%b exp=%b", k, press_pulse, k == ACC); end
            checks++; if (btn_level !== (k >= ACC)) begin errors++; $display("FAIL rst_requal k=%0d btn_level got=%b exp=%b", k, btn_level, k >= ACC); end
        end
        // asynchronous reset while pressed must drop the level without a clock edge
        rst_sync2 = 1'b1;
        #1;
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL rst_pressed btn_level got=%b exp=0", btn_level); end
        step;
        rst_sync2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step;
            checks++; if (press_pulse !== (k == ACC)) begin errors++; $display("FAIL rst_requal2 k=%0d press_pulse got=%b exp=%b", k, press_pulse, k == ACC); end
            checks++; if (release_pulse !== 1'b0) begin errors++; $display("FAIL rst_requal2 k=%0d release_pulse got=%b exp=0", k, release_pulse); end
        end
        settle;
        settle;
    endtask

    task automatic test_autorepeat;
        int npress;
        npress = 0;
        btn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step;
            if (press_pulse === 1'b1) npress++;
            checks++; if (press_pulse !== exp_press(k)) begin errors++; $display("FAIL autorepeat k=%0d press_pulse got=%b exp=%b", k, press_pulse, exp_press(k)); end
        end
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
        checks++; if (npress !== 6) begin errors++; $display("FAIL autorepeat_count got=%0d exp=6", npress); end
`else
        checks++; if (npress !== 1) begin errors++; $display("FAIL autorepeat_count got=%0d exp=1", npress); end
`endif
        settle;
    endtask

    task automatic test_back_to_back;
        int np, nr;
        logic last_was_press;
        np = 0; nr = 0; last_was_press = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                btn = (ph == 0);
                for (int k = 0; k < 8; k++) begin
                    step;
                    checks++; if ((press_pulse & release_pulse) !== 1'b0) begin errors++; $display("FAIL b2b coincident r=%0d k=%0d got=1 exp=0", r, k); end
                    checks++; if (press_pulse !== (ph == 0 && k == ACC)) begin errors++; $display("FAIL b2b r=%0d ph=%0d k=%0d press_pulse got=%b exp=%b", r, ph, k, press_pulse, ph == 0 && k == ACC); end
                    checks++; if (release_pulse !== (ph == 1 && k == ACC)) begin errors++; $display("FAIL b2b r=%0d ph=%0d k=%0d release_pulse got=%b exp=%b", r, ph, k, release_pulse, ph == 1 && k == ACC); end
                    if (press_pulse === 1'b1) begin
                        np++;
                        checks++; if (last_was_press !== 1'b0) begin errors++; $display("FAIL b2b order r=%0d press after press got=1 exp=0", r); end
                        last_was_press = 1'b1;
                    end
                    if (release_pulse === 1'b1) begin
                        nr++;
                        checks++; if (last_was_press !== 1'b1) begin errors++; $display("FAIL b2b order r=%0d release without press got=0 exp=1", r); end
                        last_was_press = 1'b0;
                    end
                end
            end
        end
        checks++; if (np !== 5) begin errors++; $display("FAIL b2b press_count got=%0d exp=5", np); end
        checks++; if (nr !== 5) begin errors++; $display("FAIL b2b release_count got=%0d exp=5", nr); end
        settle;
    endtask

    initial begin
        test_reset;
        settle;
        test_clean_press;
        test_glitch;
        test_bouncy_release;
        test_reset_mid_press;
        test_autorepeat;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
